// File: rtl/dnn_host_seq.sv
// dnn_host_seq -- host-side sequencer for the 4-cycle DNN inference datapath.
// It issues one sample per accept slot, reserves FIFO space before each issue,
// captures the paired results and flags datapath protocol violations.
// Optional feature: define DNN_HOST_SEQ_CNT_EN to add the 16-bit infer_cnt output.
// s_w packing (5-bit slots, slot 0 at the LSB):
//   slot 4*h+i (h=0..3, i=0..3) = w{i}{h+4}: w04,w14,w24,w34,w05,...,w37
//   slots 16..23 = w48,w58,w49,w59,w68,w69,w78,w79
module dnn_host_seq #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [27:0]  s_x,
  input  logic [119:0] s_w,
  output logic [6:0]   x0,
  output logic [6:0]   x1,
  output logic [6:0]   x2,
  output logic [6:0]   x3,
  output logic [4:0]   w04, w14, w24, w34,
  output logic [4:0]   w05, w15, w25, w35,
  output logic [4:0]   w06, w16, w26, w36,
  output logic [4:0]   w07, w17, w27, w37,
  output logic [4:0]   w48, w58, w49, w59,
  output logic [4:0]   w68, w69, w78, w79,
  output logic         in_ready,
  input  logic [20:0]  out0,
  input  logic [20:0]  out1,
  input  logic         out0_ready,
  input  logic         out1_ready,
  output logic         r_valid,
  input  logic         r_ready,
  output logic [20:0]  r_out0,
  output logic [20:0]  r_out1,
  output logic         err
`ifdef DNN_HOST_SEQ_CNT_EN
  ,
  output logic [15:0]  infer_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, P1, P2, P3} phase_t;

  phase_t        phase_q, phase_d;
  logic          expect_q, expect_d;
  logic [2:0]    quiet_q, quiet_d;
  logic          err_q, err_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [41:0]   mem_q [DEPTH];

  logic          quiet;
  logic          issue;
  logic          push;
  logic          pop;
  logic          violation;
  logic [CW:0]   need;
  logic [27:0]   x_bus;
  logic [119:0]  w_bus;
  logic [4:0]    w_arr [24];

  // Issue is allowed only in the accept slot, outside the post-reset quiet
  // window, and when the FIFO can still absorb every result already owed.
  assign quiet    = (quiet_q != 3'd0);
  assign need     = {1'b0, count_q} + {{CW{1'b0}}, expect_q};
  assign s_ready  = (phase_q == IDLE) && (need < DEPTH[CW:0]) && !quiet;
  assign issue    = s_valid && s_ready;
  assign in_ready = issue;

  // Sample fields reach the datapath only during the issue cycle.
  assign x_bus = issue ? s_x : '0;
  assign w_bus = issue ? s_w : '0;
  assign {x3, x2, x1, x0} = x_bus;

  generate
    for (genvar gi = 0; gi < 24; gi++) begin : g_w
      assign w_arr[gi] = w_bus[gi*5 +: 5];
    end
  endgenerate

  assign w04 = w_arr[0];  assign w14 = w_arr[1];  assign w24 = w_arr[2];  assign w34 = w_arr[3];
  assign w05 = w_arr[4];  assign w15 = w_arr[5];  assign w25 = w_arr[6];  assign w35 = w_arr[7];
  assign w06 = w_arr[8];  assign w16 = w_arr[9];  assign w26 = w_arr[10]; assign w36 = w_arr[11];
  assign w07 = w_arr[12]; assign w17 = w_arr[13]; assign w27 = w_arr[14]; assign w37 = w_arr[15];
  assign w48 = w_arr[16]; assign w58 = w_arr[17]; assign w49 = w_arr[18]; assign w59 = w_arr[19];
  assign w68 = w_arr[20]; assign w69 = w_arr[21]; assign w78 = w_arr[22]; assign w79 = w_arr[23];

  // A result is only taken when it was owed and both strobes agree.
  assign push      = expect_q && out0_ready && out1_ready;
  assign pop       = r_valid && r_ready;
  assign violation = (out0_ready != out1_ready)
                   || ((out0_ready || out1_ready) && !expect_q)
                   || (expect_q && !out0_ready && !out1_ready);

  assign r_valid = (count_q != '0);
  assign r_out0  = r_valid ? mem_q[rd_ptr_q][20:0]  : '0;
  assign r_out1  = r_valid ? mem_q[rd_ptr_q][41:21] : '0;
  assign err     = err_q;

  // Phase tracking mirrors the datapath pipeline; expect marks the capture slot.
  always_comb begin
    phase_d  = phase_q;
    case (phase_q)
      IDLE:    if (issue) phase_d = P1;
      P1:      phase_d = P2;
      P2:      phase_d = P3;
      P3:      phase_d = IDLE;
      default: phase_d = IDLE;
    endcase
    expect_d = (phase_q == P3);
  end

  // FIFO bookkeeping, quiet-window countdown and sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    quiet_d = quiet ? (quiet_q - 3'd1) : quiet_q;
    err_d   = err_q || (violation && !quiet);
  end

  // Control state; reset discards any in-flight inference and FIFO contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= IDLE;
      expect_q <= 1'b0;
      quiet_q  <= 3'd4;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      phase_q  <= phase_d;
      expect_q <= expect_d;
      quiet_q  <= quiet_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Result storage; contents are only visible through a non-zero count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {out1, out0};
  end

`ifdef DNN_HOST_SEQ_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d     = push ? (cnt_q + 16'd1) : cnt_q;
  assign infer_cnt = cnt_q;

  // Completed-inference counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 16'd0;
    else     cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_dnn_host_seq.sv
// tb_dnn_host_seq -- randomized bench for dnn_host_seq with a datapath model,
// a result scoreboard queue and a separate output monitor.
module tb_dnn_host_seq;

  localparam int DEPTH = 4;

  typedef enum int {M_GOOD, M_DROP, M_MISMATCH} mode_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [27:0]  s_x = '0;
  logic [119:0] s_w = '0;
  logic [6:0]   x0, x1, x2, x3;
  logic [4:0]   w04, w14, w24, w34, w05, w15, w25, w35;
  logic [4:0]   w06, w16, w26, w36, w07, w17, w27, w37;
  logic [4:0]   w48, w58, w49, w59, w68, w69, w78, w79;
  logic         in_ready;
  logic [20:0]  out0 = '0;
  logic [20:0]  out1 = '0;
  logic         out0_ready = 1'b0;
  logic         out1_ready = 1'b0;
  logic         r_valid;
  logic         r_ready = 1'b0;
  logic [20:0]  r_out0, r_out1;
  logic         err;
`ifdef DNN_HOST_SEQ_CNT_EN
  logic [15:0]  infer_cnt;
`endif

  logic [27:0]  dut_x;
  logic [119:0] dut_w;
  assign dut_x = {x3, x2, x1, x0};
  assign dut_w = {w79, w78, w69, w68, w59, w49, w58, w48,
                  w37, w27, w17, w07, w36, w26, w16, w06,
                  w35, w25, w15, w05, w34, w24, w14, w04};

  dnn_host_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_w(s_w),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .w04(w04), .w14(w14), .w24(w24), .w34(w34),
    .w05(w05), .w15(w15), .w25(w25), .w35(w35),
    .w06(w06), .w16(w16), .w26(w26), .w36(w36),
    .w07(w07), .w17(w17), .w27(w27), .w37(w37),
    .w48(w48), .w58(w58), .w49(w49), .w59(w59),
    .w68(w68), .w69(w69), .w78(w78), .w79(w79),
    .in_ready(in_ready),
    .out0(out0), .out1(out1), .out0_ready(out0_ready), .out1_ready(out1_ready),
    .r_valid(r_valid), .r_ready(r_ready), .r_out0(r_out0), .r_out1(r_out1),
    .err(err)
`ifdef DNN_HOST_SEQ_CNT_EN
    , .infer_cnt(infer_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Counters and scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [41:0] exp_q[$];

  // Reference model state (cycle-indexed)
  int          cyc = 0;
  int          issue_due = -1;   // cycle in which the sequencer owes a capture
  int          strobe_cyc = -1;  // cycle in which the datapath model strobes
  mode_t       strobe_mode = M_GOOD;
  mode_t       next_mode = M_GOOD;
  logic [20:0] strobe_o0 = '0;
  logic [20:0] strobe_o1 = '0;
  logic        use_fixed = 1'b0;
  logic [20:0] fixed_o0 = '0;
  logic [20:0] fixed_o1 = '0;
  logic        fixed_x = 1'b0;
  int          quiet_left = 4;
  logic        err_exp = 1'b0;
  logic        spurious = 1'b0;
  int          pushes = 0;
  int          dut_issues = 0;
  int          last_issue = -1;
  logic        track_spacing = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, check comb outputs at +1, update model at +3.
  task automatic step(input logic rs, input logic sv, input logic rr);
    logic         expect_now;
    logic         r0;
    logic         r1;
    logic         exp_sready;
    logic         viol;
    logic [127:0] rnd;
    @(negedge clk);
    rst = rs;
    if (rs) begin
      exp_q.delete();
      issue_due  = -1;
      quiet_left = 4;
      err_exp    = 1'b0;
      pushes     = 0;
    end
    expect_now = (issue_due == cyc);
    r0 = 1'b0;
    r1 = 1'b0;
    out0 = 21'($urandom);
    out1 = 21'($urandom);
    if (strobe_cyc == cyc) begin
      out0 = strobe_o0;
      out1 = strobe_o1;
      r0   = (strobe_mode != M_DROP);
      r1   = (strobe_mode == M_GOOD);
    end else if (spurious) begin
      r0 = 1'b1;
      r1 = 1'b1;
    end
    out0_ready = r0;
    out1_ready = r1;
    s_valid    = sv;
    r_ready    = rr;
    if (!fixed_x) begin
      s_x = 28'($urandom);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      s_w = rnd[119:0];
    end
    #1;
    exp_sready = !rs && (quiet_left == 0) && !(issue_due != -1 && cyc < issue_due)
                 && ((exp_q.size() + (expect_now ? 1 : 0)) < DEPTH);
    chk("s_ready", 128'(s_ready), 128'(exp_sready));
    chk("err", 128'(err), 128'(err_exp));
    chk("in_ready", 128'(in_ready), 128'(sv && exp_sready));
    if (in_ready) begin
      dut_issues++;
      if (track_spacing && last_issue >= 0) chk("issue_spacing", 128'(cyc - last_issue), 128'(4));
      last_issue = cyc;
    end
    if (sv && exp_sready) begin
      chk("x_pass", 128'(dut_x), 128'(s_x));
      chk("w_pass", 128'(dut_w), 128'(s_w));
      issue_due   = cyc + 4;
      strobe_cyc  = cyc + 4;
      strobe_mode = next_mode;
      strobe_o0   = use_fixed ? fixed_o0 : 21'($urandom);
      strobe_o1   = use_fixed ? fixed_o1 : 21'($urandom);
    end else begin
      chk("x_idle", 128'(dut_x), 128'(0));
      chk("w_idle", 128'(dut_w), 128'(0));
    end
    #2;
    viol = (r0 != r1) || ((r0 || r1) && !expect_now) || (expect_now && !r0 && !r1);
    if (!rs) begin
      if (quiet_left == 0 && viol) err_exp = 1'b1;
      if (expect_now && r0 && r1) begin
        exp_q.push_back({out1, out0});
        pushes++;
      end
      if (quiet_left > 0) quiet_left--;
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compares every presented result against the scoreboard.
  initial begin
    logic [41:0] e;
    forever begin
      @(negedge clk);
      #2;
      chk("r_valid", 128'(r_valid), 128'(exp_q.size() != 0));
      if (r_valid && r_ready) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("result", 128'({r_out1, r_out0}), 128'(e));
          $display("result popped: out0=%0h out1=%0h", r_out0, r_out1);
        end
      end else if (!r_valid) begin
        chk("r_out_empty", 128'({r_out1, r_out0}), 128'(0));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rnd;
    int           n;
    // Reset state
    do_reset();

    // Single inference with fixed values
    fixed_x  = 1'b1;
    s_x      = {7'd1, 7'd2, 7'd3, 7'd4};
    rnd      = {$urandom, $urandom, $urandom, $urandom};
    s_w      = rnd[119:0];
    use_fixed = 1'b1;
    fixed_o0 = 21'(-5);
    fixed_o1 = 21'(17);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("single_r_valid", 128'(r_valid), 128'(1));
    chk("single_r_out0", 128'(r_out0), 128'(21'h1FFFFB));
    chk("single_r_out1", 128'(r_out1), 128'(17));
    chk("single_err", 128'(err), 128'(0));
    fixed_x   = 1'b0;
    use_fixed = 1'b0;
    drain();

    // Back-to-back issue
    do_reset();
    dut_issues    = 0;
    last_issue    = -1;
    track_spacing = 1'b1;
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b1);
    track_spacing = 1'b0;
    chk("b2b_issues", 128'(dut_issues), 128'(8));
    drain();
`ifdef DNN_HOST_SEQ_CNT_EN
    chk("b2b_infer_cnt", 128'(infer_cnt), 128'(16'd8));
`endif

    // Backpressure
    dut_issues = 0;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);
    chk("bp_issues", 128'(dut_issues), 128'(DEPTH));
    dut_issues = 0;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    chk("bp_one_more", 128'(dut_issues), 128'(1));
    drain();

    // Random traffic
    for (int i = 0; i < 300; i++) step(1'b0, ($urandom % 3) != 0, ($urandom % 2) != 0);
    drain();
`ifdef DNN_HOST_SEQ_CNT_EN
    chk("rand_infer_cnt", 128'(infer_cnt), 128'(pushes[15:0]));
`endif

    // Missing result
    next_mode = M_DROP;
    step(1'b0, 1'b1, 1'b1);
    next_mode = M_GOOD;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
    chk("drop_err", 128'(err), 128'(1));
    do_reset();

    // Mismatched strobes
    next_mode = M_MISMATCH;
    step(1'b0, 1'b1, 1'b1);
    next_mode = M_GOOD;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
    chk("mismatch_err", 128'(err), 128'(1));
    do_reset();

    // Unexpected strobe in IDLE
    spurious = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    spurious = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("spurious_err", 128'(err), 128'(1));
    do_reset();

    // Reset in the middle of an inference with two results buffered
    dut_issues = 0;
    n = 0;
    while (dut_issues < 3 && n < 20) begin
      step(1'b0, 1'b1, 1'b0);
      n++;
    end
    chk("midrst_issues", 128'(dut_issues), 128'(3));
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    chk("midrst_r_valid", 128'(r_valid), 128'(0));
    chk("midrst_err", 128'(err), 128'(0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
